// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide sequencer.
//   - mdu_op_e    : operation encodings as presented on op_i
//   - mdu_state_e : sequencer states
//   - MDU_WIDTH / ITER / CNT_W : default operand width, iteration count,
//     iteration counter width
//   - mdu_is_signed : true for the signed operations (MULT, DIV)
package mdu_pkg;

    localparam int MDU_WIDTH = 32;
    localparam int ITER      = MDU_WIDTH;
    localparam int CNT_W     = $clog2(MDU_WIDTH) + 1;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'd0,
        MDU_MULTU = 2'd1,
        MDU_DIV   = 2'd2,
        MDU_DIVU  = 2'd3
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mdu_state_e;

    function automatic logic mdu_is_signed(input mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// mdu_sign_fix: combinational conditional two's-complement negate.
// Used both to take operand magnitudes and to restore result signs.
//   neg_i : 1 = output is -in_i, 0 = output is in_i
//   in_i  : W-bit value
//   out_o : W-bit result
module mdu_sign_fix #(
    parameter int W = 32
) (
    input  logic         neg_i,
    input  logic [W-1:0] in_i,
    output logic [W-1:0] out_o
);

    assign out_o = neg_i ? (~in_i + {{(W-1){1'b0}}, 1'b1}) : in_i;

endmodule

// File: rtl/mdu_seq_ctrl.sv
// mdu_seq_ctrl: multi-cycle MULT/MULTU/DIV/DIVU sequencer for the EX stage.
// Shift-add multiplier and restoring divider, one iteration per cycle,
// followed by a sign fix-up cycle that commits HI/LO.
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-low reset
//   start_i : start request, honoured in IDLE/DONE only
//   op_i    : 0=MULT 1=MULTU 2=DIV 3=DIVU, sampled with start_i
//   src1_i  : multiplicand / dividend
//   src2_i  : multiplier / divisor
//   kill_i  : pipeline flush, aborts any in-flight operation
//   busy_o  : high while in CALC or FIX
//   done_o  : one-cycle pulse once HI/LO hold the new result
//   hi_o    : HI register (product upper half / remainder)
//   lo_o    : LO register (product lower half / quotient)
// Build option: define MDU_EARLY_TERM_EN to let multiplies leave CALC as
// soon as the remaining multiplier bits are all zero.
module mdu_seq_ctrl
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic             kill_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    mdu_state_e         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    mdu_op_e            op_q, op_d;
    logic               sign1_q, sign1_d, sign2_q, sign2_d;
    // Multiply: acc = running product, opa = shifted multiplicand,
    //           opb = multiplier shifting right.
    // Divide:   acc = {remainder, quotient/dividend}, opb = divisor.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

    mdu_op_e            op_in;
    logic               in_signed;
    logic [WIDTH-1:0]   mag1, mag2;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    logic               is_mul;
    logic [WIDTH-1:0]   mplier_nx;
    logic [WIDTH:0]     rem_sh, rem_diff;
    logic               last_iter;

    assign op_in     = mdu_op_e'(op_i);
    assign in_signed = mdu_is_signed(op_in);
    assign is_mul    = (op_q == MDU_MULT) || (op_q == MDU_MULTU);

    mdu_sign_fix #(.W(WIDTH)) u_mag1 (
        .neg_i (in_signed & src1_i[WIDTH-1]),
        .in_i  (src1_i),
        .out_o (mag1)
    );

    mdu_sign_fix #(.W(WIDTH)) u_mag2 (
        .neg_i (in_signed & src2_i[WIDTH-1]),
        .in_i  (src2_i),
        .out_o (mag2)
    );

    mdu_sign_fix #(.W(2*WIDTH)) u_prod (
        .neg_i (sign1_q ^ sign2_q),
        .in_i  (acc_q),
        .out_o (prod_fix)
    );

    mdu_sign_fix #(.W(WIDTH)) u_quot (
        .neg_i (sign1_q ^ sign2_q),
        .in_i  (acc_q[WIDTH-1:0]),
        .out_o (quot_fix)
    );

    // Remainder follows the dividend sign; for divide-by-zero this also
    // turns the magnitude back into the dividend as it was presented.
    mdu_sign_fix #(.W(WIDTH)) u_rem (
        .neg_i (sign1_q),
        .in_i  (acc_q[2*WIDTH-1:WIDTH]),
        .out_o (rem_fix)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        sign1_d   = sign1_q;
        sign2_d   = sign2_q;
        acc_d     = acc_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        mplier_nx = opb_q >> 1;
        rem_sh    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        rem_diff  = rem_sh - {1'b0, opb_q};
`ifdef MDU_EARLY_TERM_EN
        last_iter = (cnt_q == CW'(WIDTH - 1)) || (is_mul && (mplier_nx == '0));
`else
        last_iter = (cnt_q == CW'(WIDTH - 1));
`endif

        case (state_q)
            IDLE, DONE: begin
                if (start_i && !kill_i) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    op_d    = op_in;
                    sign1_d = in_signed & src1_i[WIDTH-1];
                    sign2_d = in_signed & src2_i[WIDTH-1];
                    opa_d   = {{WIDTH{1'b0}}, mag1};
                    opb_d   = mag2;
                    acc_d   = ((op_in == MDU_MULT) || (op_in == MDU_MULTU))
                              ? '0 : {{WIDTH{1'b0}}, mag1};
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (kill_i) begin
                    state_d = IDLE;
                end else begin
                    if (is_mul) begin
                        acc_d = acc_q + (opb_q[0] ? opa_q : '0);
                        opa_d = opa_q << 1;
                        opb_d = mplier_nx;
                    end else if (!rem_diff[WIDTH]) begin
                        // Trial subtraction fits: keep difference, quotient bit 1.
                        acc_d = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (last_iter) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                if (kill_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                    if (is_mul) begin
                        {hi_d, lo_d} = prod_fix;
                    end else if (opb_q == '0) begin
                        hi_d = rem_fix;
                        lo_d = '1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= MDU_MULT;
            sign1_q <= 1'b0;
            sign2_q <= 1'b0;
            acc_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            sign1_q <= sign1_d;
            sign2_q <= sign2_d;
            acc_q   <= acc_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy_o = (state_q == CALC) || (state_q == FIX);
    assign done_o = (state_q == DONE);
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// tb_mdu_seq_ctrl: directed bench for mdu_seq_ctrl. Cycle numbering: the
// start request is sampled at edge k; the first negedge after it is cycle
// k+1. Outputs are sampled on the falling edge.
module tb_mdu_seq_ctrl;

`ifdef MDU_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic        kill = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_chk = 0;
    int n_fail = 0;

    mdu_seq_ctrl dut (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .start_i (start),
        .op_i    (op),
        .src1_i  (src1),
        .src2_i  (src2),
        .kill_i  (kill),
        .busy_o  (busy),
        .done_o  (done),
        .hi_o    (hi),
        .lo_o    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Presents a request for one cycle; returns in cycle k+1.
    task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        src1  = a;
        src2  = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int exp_cyc,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int done_cyc;
        int busy_bad;
        done_cyc = 0;
        busy_bad = 0;
        @(negedge clk);
        start_op(o, a, b);
        for (int j = 1; j <= 40; j++) begin
            if (busy !== (j < exp_cyc)) busy_bad++;
            if (done === 1'b1) begin
                done_cyc = j;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_done_cyc"}, 64'(done_cyc), 64'(exp_cyc));
        chk({tag, "_busy"}, 64'(busy_bad), 64'd0);
        chk({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        chk({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    endtask

    // Counts done pulses over a window; used where nothing may complete.
    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int j = 0; j < cycles; j++) begin
            @(negedge clk);
            if (done === 1'b1) n++;
        end
    endtask

    initial begin
        int n;
        int done_cyc;
        int pulse_cyc;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst_n = 1'b1;

        // Signed/unsigned arithmetic and boundary operands
        run_op("mult_m3x5", OP_MULT, 32'hFFFF_FFFD, 32'd5, EARLY ? 5 : 34,
               32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("div_m7d2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_100d7", OP_DIVU, 32'd100, 32'd7, 34, 32'd2, 32'd14);
        run_op("divu_5d0", OP_DIVU, 32'd5, 32'd0, 34, 32'd5, 32'hFFFF_FFFF);
        run_op("mult_minxmin", OP_MULT, 32'h8000_0000, 32'h8000_0000, 34,
               32'h4000_0000, 32'h0000_0000);
        run_op("div_min_dm1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 34,
               32'h0000_0000, 32'h8000_0000);
        run_op("multu_big", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34,
               32'hFFFF_FFFE, 32'h0000_0001);

        // start while busy is ignored
        pulse_cyc = EARLY ? 2 : 10;
        done_cyc = 0;
        @(negedge clk);
        start_op(OP_MULTU, 32'd2, 32'd3);
        for (int j = 1; j <= 40; j++) begin
            if (done === 1'b1) begin
                done_cyc = j;
                break;
            end
            if (j == pulse_cyc) start_op(OP_DIVU, 32'd100, 32'd7);
            else @(negedge clk);
        end
        chk("ignore_done_cyc", 64'(done_cyc), EARLY ? 64'd4 : 64'd34);
        chk("ignore_hi", 64'(hi), 64'd0);
        chk("ignore_lo", 64'(lo), 64'd6);
        count_done(40, n);
        chk("ignore_no_second_done", 64'(n), 64'd0);

        // kill mid-operation
        @(negedge clk);
        start_op(OP_DIVU, 32'd1000, 32'd3);
        repeat (19) @(negedge clk);
        chk("kill_busy_c20", 64'(busy), 64'd1);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        chk("kill_busy_c21", 64'(busy), 64'd0);
        count_done(40, n);
        chk("kill_no_done", 64'(n), 64'd0);
        chk("kill_hi", 64'(hi), 64'd0);
        chk("kill_lo", 64'(lo), 64'd6);

        // kill together with start: nothing starts
        kill = 1'b1;
        start_op(OP_MULTU, 32'd9, 32'd9);
        kill = 1'b0;
        chk("killstart_busy", 64'(busy), 64'd0);
        count_done(40, n);
        chk("killstart_no_done", 64'(n), 64'd0);

        // Asynchronous reset mid-divide
        start_op(OP_DIVU, 32'd100, 32'd7);
        repeat (14) @(negedge clk);
        chk("mid_busy_c15", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_hi", 64'(hi), 64'd0);
        chk("midrst_lo", 64'(lo), 64'd6 ^ 64'd6);
        chk("midrst_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst_divu", OP_DIVU, 32'hFFFF_FFFF, 32'h10, 34,
               32'h0000_000F, 32'h0FFF_FFFF);

        // Early-termination sensitive multiply
        run_op("multu_7x3", OP_MULTU, 32'd7, 32'd3, EARLY ? 4 : 34, 32'd0, 32'd21);
        run_op("multu_x0", OP_MULTU, 32'd7, 32'd0, EARLY ? 3 : 34, 32'd0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
